// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types and constants for the pipeline hazard logic
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sb_slot_t;

  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;

  function automatic logic slot_match(input sb_slot_t slot, input logic [4:0] rs);
    return slot.vld && (slot.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker for EX/MEM/WB with source match
module hazard_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int WB_BYPASS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [4:0] issue_rd,
  input  logic       insn_vld,
  input  logic [4:0] rs1_addr,
  input  logic       rs1_used,
  input  logic [4:0] rs2_addr,
  input  logic       rs2_used,
  output logic       rs1_hit,
  output logic       rs2_hit
);

  sb_slot_t sb [SB_DEPTH];
  sb_slot_t ex_next;

  always_comb begin
    ex_next     = '0;
    ex_next.vld = issue;
    ex_next.rd  = issue ? issue_rd : 5'd0;
  end

  // A non-issuing ID slot loads an invalid entry so bubbles travel down the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[SB_WB]  <= sb[SB_MEM];
      sb[SB_MEM] <= sb[SB_EX];
      sb[SB_EX]  <= ex_next;
    end
  end

  function automatic logic src_hit(input logic [4:0] rs, input logic used);
    logic any;
    any = slot_match(sb[SB_EX], rs) || slot_match(sb[SB_MEM], rs) ||
          ((WB_BYPASS == 0) && slot_match(sb[SB_WB], rs));
    return insn_vld && used && (rs != 5'd0) && any;
  endfunction

  assign rs1_hit = src_hit(rs1_addr, rs1_used);
  assign rs2_hit = src_hit(rs2_addr, rs2_used);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for the non-forwarding 5-stage pipeline
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_insn_vld,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_id_rd_addr,
  input  logic             i_id_rd_wren,
  input  logic             i_ex_redirect,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  logic      rs1_hit;
  logic      rs2_hit;
  logic      hazard;
  logic      data_stall;
  logic      issue;
  hz_state_e state;

  hazard_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
    .clk      (i_clk),
    .rst      (i_rst),
    .issue    (issue),
    .issue_rd (i_id_rd_addr),
    .insn_vld (i_id_insn_vld),
    .rs1_addr (i_id_rs1_addr),
    .rs1_used (i_id_rs1_used),
    .rs2_addr (i_id_rs2_addr),
    .rs2_used (i_id_rs2_used),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit)
  );

  assign hazard     = rs1_hit || rs2_hit;
  // The ID instruction is wrong-path on a redirect, so its hazard does not matter.
  assign data_stall = hazard && !i_ex_redirect;
  assign issue      = i_id_insn_vld && !hazard && !i_ex_redirect &&
                      i_id_rd_wren && (i_id_rd_addr != 5'd0);

  always_comb begin
    o_pc_stall   = 1'b0;
    o_ifid_stall = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    if (i_ex_redirect) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (hazard) begin
      o_pc_stall   = 1'b1;
      o_ifid_stall = 1'b1;
      o_idex_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= RUN;
    end else if (i_ex_redirect) begin
      state <= FLUSH;
    end else if (hazard) begin
      state <= STALL;
    end else begin
      state <= RUN;
    end
  end

  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_stall_cycles <= '0;
      o_flush_events <= '0;
    end else begin
      if (data_stall && (o_stall_cycles != {CNT_W{1'b1}})) begin
        o_stall_cycles <= o_stall_cycles + 1'b1;
      end
      if (i_ex_redirect && (o_flush_events != {CNT_W{1'b1}})) begin
        o_flush_events <= o_flush_events + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl, with and without WB bypass
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       insn_vld;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic       rs1_used;
  logic       rs2_used;
  logic [4:0] rd_addr;
  logic       rd_wren;
  logic       redirect;

  logic        pc_stall0, ifid_stall0, ifid_flush0, idex_flush0;
  logic        pc_stall1, ifid_stall1, ifid_flush1, idex_flush1;
  logic [1:0]  state0, state1;
  logic [31:0] stalls0, stalls1, flushes0, flushes1;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_STALL = 4'b1101;
  localparam logic [3:0] C_FLUSH = 4'b0011;

  hazard_ctrl #(.WB_BYPASS(0), .CNT_W(32)) u_nb (
    .i_clk(clk), .i_rst(rst), .i_id_insn_vld(insn_vld),
    .i_id_rs1_addr(rs1_addr), .i_id_rs2_addr(rs2_addr),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd_addr(rd_addr), .i_id_rd_wren(rd_wren), .i_ex_redirect(redirect),
    .o_pc_stall(pc_stall0), .o_ifid_stall(ifid_stall0), .o_ifid_flush(ifid_flush0),
    .o_idex_flush(idex_flush0), .o_state(state0),
    .o_stall_cycles(stalls0), .o_flush_events(flushes0)
  );

  hazard_ctrl #(.WB_BYPASS(1), .CNT_W(32)) u_bp (
    .i_clk(clk), .i_rst(rst), .i_id_insn_vld(insn_vld),
    .i_id_rs1_addr(rs1_addr), .i_id_rs2_addr(rs2_addr),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd_addr(rd_addr), .i_id_rd_wren(rd_wren), .i_ex_redirect(redirect),
    .o_pc_stall(pc_stall1), .o_ifid_stall(ifid_stall1), .o_ifid_flush(ifid_flush1),
    .o_idex_flush(idex_flush1), .o_state(state1),
    .o_stall_cycles(stalls1), .o_flush_events(flushes1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic w, input logic rdr);
    insn_vld = v;  rs1_addr = r1; rs1_used = u1;
    rs2_addr = r2; rs2_used = u2; rd_addr  = rd;
    rd_wren  = w;  redirect = rdr;
  endtask

  task automatic idle();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_ctrl(input string tag, input logic [3:0] exp0, input logic [3:0] exp1);
    check({tag, "_nb"}, {28'd0, pc_stall0, ifid_stall0, ifid_flush0, idex_flush0}, {28'd0, exp0});
    check({tag, "_bp"}, {28'd0, pc_stall1, ifid_stall1, ifid_flush1, idex_flush1}, {28'd0, exp1});
  endtask

  task automatic chk_cnt(input string tag, input int s0, input int s1, input int f);
    check({tag, "_stall_nb"}, stalls0, s0);
    check({tag, "_stall_bp"}, stalls1, s1);
    check({tag, "_flush_nb"}, flushes0, f);
    check({tag, "_flush_bp"}, flushes1, f);
  endtask

  task automatic drain();
    repeat (3) begin
      @(negedge clk);
      idle();
    end
  endtask

  // Producer addi x5 followed directly by dependent add x6,x5,x0.
  task automatic back_to_back(input string tag);
    @(negedge clk);
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    #1 chk_ctrl({tag, "_prod"}, C_NONE, C_NONE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
      #1 chk_ctrl($sformatf("%s_cyc%0d", tag, i),
                  (i < 3) ? C_STALL : C_NONE, (i < 2) ? C_STALL : C_NONE);
      if (i == 1) check({tag, "_state_stall"}, {30'd0, state0}, 32'd1);
    end
    @(negedge clk);
    idle();
    #1 check({tag, "_state_run"}, {30'd0, state0}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (3) begin
      @(negedge clk);
      id_set(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1 chk_ctrl("rst_ctrl", C_NONE, C_NONE);
    check("rst_state_nb", {30'd0, state0}, 32'd0);
    check("rst_state_bp", {30'd0, state1}, 32'd0);
    chk_cnt("rst", 0, 0, 0);
    for (int r = 1; r < 32; r += 9) begin
      id_set(1'b1, 5'(r), 1'b1, 5'(31 - r), 1'b1, 5'd0, 1'b0, 1'b0);
      #1 chk_ctrl($sformatf("rst_rs%0d", r), C_NONE, C_NONE);
    end
    idle();

    back_to_back("b2b");
    chk_cnt("b2b", 3, 2, 0);
    drain();

    // Producer two ahead with an unrelated writer between.
    @(negedge clk);
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      id_set(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
      #1 chk_ctrl($sformatf("gap2_cyc%0d", i),
                  (i < 2) ? C_STALL : C_NONE, (i < 1) ? C_STALL : C_NONE);
    end
    @(negedge clk);
    idle();
    #1 chk_cnt("gap2", 5, 3, 0);
    drain();

    // x0 as destination and source, and an unused rs2 that matches.
    @(negedge clk);
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
    #1 chk_ctrl("x0_read", C_NONE, C_NONE);
    @(negedge clk);
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    id_set(1'b1, 5'd3, 1'b1, 5'd9, 1'b0, 5'd12, 1'b1, 1'b0);
    #1 chk_ctrl("rs2_unused", C_NONE, C_NONE);
    @(negedge clk);
    idle();
    #1 chk_cnt("nostall", 5, 3, 0);
    drain();

    // Redirect over a live hazard, then back-to-back redirects.
    @(negedge clk);
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    #1 chk_ctrl("redir_hz", C_FLUSH, C_FLUSH);
    @(negedge clk);
    id_set(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 1'b0);
    #1 chk_ctrl("redir_bubble", C_NONE, C_NONE);
    check("redir_state_nb", {30'd0, state0}, 32'd2);
    check("redir_state_bp", {30'd0, state1}, 32'd2);
    chk_cnt("redir", 5, 3, 1);
    id_set(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd13, 1'b0, 1'b0);
    #1 chk_ctrl("redir_mem_kept", C_STALL, C_STALL);
    @(negedge clk);
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 chk_ctrl("redir2_a", C_FLUSH, C_FLUSH);
    check("redir2_state", {30'd0, state0}, 32'd1);
    @(negedge clk);
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 chk_ctrl("redir2_b", C_FLUSH, C_FLUSH);
    @(negedge clk);
    idle();
    #1 chk_cnt("redir2", 6, 4, 3);
    check("redir2_state_end", {30'd0, state1}, 32'd2);
    drain();

    // Reset asserted in the second stall cycle.
    @(negedge clk);
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    #1 chk_ctrl("mid_stall", C_STALL, C_STALL);
    rst = 1'b0;
    #1 chk_ctrl("mid_rst", C_NONE, C_NONE);
    check("mid_rst_state", {30'd0, state0}, 32'd0);
    chk_cnt("mid_rst", 0, 0, 0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    back_to_back("again");
    chk_cnt("again", 3, 2, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
